// File: rtl/forwarding_operand_unit.sv
// EX-stage operand forwarding for NUM_OPS channels, EX/MEM over MEM/WB, XZR never forwarded, with per-channel stall hold.
// Zero-cycle combinational path in LIVE; in HOLD the outputs come from registers only. Optional counters under FWD_PERF_CNT_EN.
// Backpressure: none; stall/flush from the ID/EX control decide capture and release of the hold registers.
module forwarding_operand_unit #(
    parameter int DATA_W     = 64,
    parameter int NUM_OPS    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [NUM_OPS*REG_ADDR_W-1:0] idex_rs,
    input  logic [NUM_OPS*DATA_W-1:0]     idex_rdata,
    input  logic                          exmem_regwrite,
    input  logic [REG_ADDR_W-1:0]         exmem_rd,
    input  logic [DATA_W-1:0]             exmem_result,
    input  logic                          memwb_regwrite,
    input  logic [REG_ADDR_W-1:0]         memwb_rd,
    input  logic [DATA_W-1:0]             memwb_result,
    output logic [NUM_OPS*DATA_W-1:0]     operand,
    output logic [NUM_OPS*2-1:0]          fwd_sel,
    output logic [NUM_OPS-1:0]            held
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [NUM_OPS*64-1:0]         perf_cnt
`endif
);

    localparam logic [REG_ADDR_W-1:0] XZR = '1;

    typedef enum logic {LIVE = 1'b0, HOLD = 1'b1} hold_state_t;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ch
        logic [REG_ADDR_W-1:0] w_rs;
        logic [DATA_W-1:0]     w_rdata;
        logic [1:0]            w_sel;
        logic [DATA_W-1:0]     w_live;
        hold_state_t           r_state;
        logic [DATA_W-1:0]     r_hold;

        assign w_rs    = idex_rs[g*REG_ADDR_W +: REG_ADDR_W];
        assign w_rdata = idex_rdata[g*DATA_W +: DATA_W];

        always_comb begin
            w_sel  = 2'b00;
            w_live = w_rdata;
            if (w_rs != XZR) begin
                if (exmem_regwrite && (exmem_rd == w_rs)) begin
                    w_sel  = 2'b10;
                    w_live = exmem_result;
                end else if (memwb_regwrite && (memwb_rd == w_rs)) begin
                    w_sel  = 2'b01;
                    w_live = memwb_result;
                end
            end
        end

        // Capture only on entry to HOLD so the value survives the producer draining out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= LIVE;
                r_hold  <= '0;
            end else begin
                case (r_state)
                    LIVE: begin
                        if (stall && !flush) begin
                            r_state <= HOLD;
                            r_hold  <= w_live;
                        end
                    end
                    HOLD: begin
                        if (!stall || flush) begin
                            r_state <= LIVE;
                        end
                    end
                    default: r_state <= LIVE;
                endcase
            end
        end

        assign held[g]                   = (r_state == HOLD);
        assign operand[g*DATA_W +: DATA_W] = (r_state == HOLD) ? r_hold : w_live;
        assign fwd_sel[g*2 +: 2]         = (r_state == HOLD) ? 2'b11 : w_sel;

`ifdef FWD_PERF_CNT_EN
        logic [31:0] r_cnt_exmem;
        logic [31:0] r_cnt_memwb;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt_exmem <= '0;
                r_cnt_memwb <= '0;
            end else if ((r_state == LIVE) && !stall) begin
                if ((w_sel == 2'b10) && (r_cnt_exmem != 32'hFFFF_FFFF)) begin
                    r_cnt_exmem <= r_cnt_exmem + 32'd1;
                end
                if ((w_sel == 2'b01) && (r_cnt_memwb != 32'hFFFF_FFFF)) begin
                    r_cnt_memwb <= r_cnt_memwb + 32'd1;
                end
            end
        end

        assign perf_cnt[g*64 +: 64] = {r_cnt_exmem, r_cnt_memwb};
`endif
    end

endmodule

// File: tb/tb_forwarding_operand_unit.sv
// Self-checking bench for forwarding_operand_unit: directed literal cases plus randomized traffic vs a behavioural model.
module tb_forwarding_operand_unit;

    localparam int DW  = 64;
    localparam int NOP = 2;
    localparam int AW  = 5;

    logic                clk;
    logic                rst_n;
    logic                stall;
    logic                flush;
    logic [NOP*AW-1:0]   idex_rs;
    logic [NOP*DW-1:0]   idex_rdata;
    logic                exmem_regwrite;
    logic [AW-1:0]       exmem_rd;
    logic [DW-1:0]       exmem_result;
    logic                memwb_regwrite;
    logic [AW-1:0]       memwb_rd;
    logic [DW-1:0]       memwb_result;
    logic [NOP*DW-1:0]   operand;
    logic [NOP*2-1:0]    fwd_sel;
    logic [NOP-1:0]      held;
`ifdef FWD_PERF_CNT_EN
    logic [NOP*64-1:0]   perf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model state: per channel, whether a value is being held and what it is.
    bit          m_held [NOP];
    logic [DW-1:0] m_hold [NOP];

    forwarding_operand_unit #(.DATA_W(DW), .NUM_OPS(NOP), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .idex_rs(idex_rs), .idex_rdata(idex_rdata),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .operand(operand), .fwd_sel(fwd_sel), .held(held)
`ifdef FWD_PERF_CNT_EN
        , .perf_cnt(perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {select, value} for channel i from the current inputs.
    function automatic logic [DW+1:0] model_live(int i);
        logic [AW-1:0] rs;
        rs = idex_rs[i*AW +: AW];
        if (rs != 5'd31 && exmem_regwrite && exmem_rd == rs) return {2'b10, exmem_result};
        if (rs != 5'd31 && memwb_regwrite && memwb_rd == rs) return {2'b01, memwb_result};
        return {2'b00, idex_rdata[i*DW +: DW]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NOP; i++) begin
            if (!rst_n) begin
                m_held[i] = 0;
                m_hold[i] = '0;
            end else if (flush) begin
                m_held[i] = 0;
            end else if (stall) begin
                if (!m_held[i]) begin
                    m_hold[i] = model_live(i)[DW-1:0];
                    m_held[i] = 1;
                end
            end else begin
                m_held[i] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NOP; i++) begin
                logic [DW+1:0] lv;
                logic [DW+2:0] exp_v;
                logic [DW+2:0] act_v;
                lv = model_live(i);
                if (m_held[i]) exp_v = {1'b1, 2'b11, m_hold[i]};
                else           exp_v = {1'b0, lv};
                act_v = {held[i], fwd_sel[i*2 +: 2], operand[i*DW +: DW]};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_ch%0d: got held/sel/op %h, expected %h at %0t", i, act_v, exp_v, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int i, input logic [AW-1:0] v);
        idex_rs[i*AW +: AW] = v;
    endtask

    task automatic set_rdata(input int i, input logic [DW-1:0] v);
        idex_rdata[i*DW +: DW] = v;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0;
        idex_rs = '0; idex_rdata = '0;
        exmem_regwrite = 0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        set_rs(0, 5'd2); set_rdata(0, 64'h55);
        exmem_regwrite = 1; exmem_rd = 5'd2; exmem_result = 64'hC0DE;
        #2;
        check("reset_held", {62'd0, held}, 64'd0);
        check("reset_live_sel0", {62'd0, fwd_sel[1:0]}, 64'd2);
        check("reset_live_op0", operand[63:0], 64'hC0DE);
        chk_en = 1;
        step();
        rst_n = 1;
        idle_inputs();

        // Priority: both stages match, EX/MEM wins.
        set_rs(0, 5'd3); set_rdata(0, 64'h11);
        exmem_regwrite = 1; exmem_rd = 5'd3; exmem_result = 64'hAA;
        memwb_regwrite = 1; memwb_rd = 5'd3; memwb_result = 64'hBB;
        @(negedge clk);
        check("prio_op0", operand[63:0], 64'hAA);
        check("prio_sel0", {62'd0, fwd_sel[1:0]}, 64'd2);
        step();

        // XZR is never forwarded.
        set_rs(1, 5'd31); set_rdata(1, 64'h0);
        exmem_rd = 5'd31; memwb_rd = 5'd31;
        @(negedge clk);
        check("xzr_op1", operand[127:64], 64'h0);
        check("xzr_sel1", {62'd0, fwd_sel[3:2]}, 64'd0);
        set_rdata(1, 64'h5555);
        #1;
        check("xzr_pass_op1", operand[127:64], 64'h5555);
        step();

        // Stall hold across three stall cycles while the producer drains.
        idle_inputs();
        set_rs(0, 5'd5); set_rdata(0, 64'h77);
        exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 64'h1234;
        stall = 1;
        @(negedge clk);
        check("stall1_op0", operand[63:0], 64'h1234);
        check("stall1_held0", {63'd0, held[0]}, 64'd0);
        step();
        exmem_regwrite = 0;
        memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 64'h9999;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            check("stallN_op0", operand[63:0], 64'h1234);
            check("stallN_sel0", {62'd0, fwd_sel[1:0]}, 64'd3);
            check("stallN_held0", {63'd0, held[0]}, 64'd1);
            step();
        end
        stall = 0;
        @(negedge clk);
        check("release_op0", operand[63:0], 64'h1234);
        check("release_held0", {63'd0, held[0]}, 64'd1);
        step();
        @(negedge clk);
        check("after_op0", operand[63:0], 64'h9999);
        check("after_sel0", {62'd0, fwd_sel[1:0]}, 64'd1);
        check("after_held0", {63'd0, held[0]}, 64'd0);
        step();

        // Flush during hold: back to live with no capture.
        idle_inputs();
        set_rs(0, 5'd6); set_rdata(0, 64'h66);
        exmem_regwrite = 1; exmem_rd = 5'd6; exmem_result = 64'hE1;
        stall = 1;
        step();
        exmem_result = 64'hE2;
        flush = 1;
        @(negedge clk);
        check("flush_pre_op0", operand[63:0], 64'hE1);
        step();
        flush = 0; stall = 0; exmem_result = 64'hE3;
        @(negedge clk);
        check("flush_held0", {63'd0, held[0]}, 64'd0);
        check("flush_op0", operand[63:0], 64'hE3);
        check("flush_sel0", {62'd0, fwd_sel[1:0]}, 64'd2);
        step();

        // Reset asserted mid-hold takes effect without a clock edge.
        idle_inputs();
        set_rs(0, 5'd7);
        exmem_regwrite = 1; exmem_rd = 5'd7; exmem_result = 64'h42;
        stall = 1;
        step();
        exmem_result = 64'h43;
        check("prereset_held0", {63'd0, held[0]}, 64'd1);
        #2 rst_n = 0;
        #1;
        check("rst_held0", {63'd0, held[0]}, 64'd0);
        check("rst_sel0", {62'd0, fwd_sel[1:0]}, 64'd2);
        check("rst_op0", operand[63:0], 64'h43);
        step();
        rst_n = 1;
        idle_inputs();
        step();

`ifdef FWD_PERF_CNT_EN
        @(negedge clk);
        force dut.g_ch[0].r_cnt_exmem = 32'hFFFF_FFFE;
        force dut.g_ch[0].r_cnt_memwb = 32'hFFFF_FFFE;
        #1;
        release dut.g_ch[0].r_cnt_exmem;
        release dut.g_ch[0].r_cnt_memwb;
        step();
        set_rs(0, 5'd9);
        exmem_regwrite = 1; exmem_rd = 5'd9; exmem_result = 64'h9;
        repeat (3) step();
        idle_inputs();
        @(negedge clk);
        check("cnt_exmem_sat", {32'd0, perf_cnt[63:32]}, 64'hFFFF_FFFF);
        check("cnt_memwb_keep", {32'd0, perf_cnt[31:0]}, 64'hFFFF_FFFE);
        step();
`endif

        // Randomized traffic; small register range so matches are frequent.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NOP; i++) begin
                set_rs(i, ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3)));
                set_rdata(i, {$urandom, $urandom});
            end
            exmem_regwrite = 1'($urandom);
            exmem_rd       = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            exmem_result   = {$urandom, $urandom};
            memwb_regwrite = 1'($urandom);
            memwb_rd       = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            memwb_result   = {$urandom, $urandom};
            stall          = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 7) == 0);
            step();
        end

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/forwarding_operand_unit.md
# forwarding_operand_unit

Parametrised EX-stage operand forwarding unit for the LEGv8 pipeline. It replaces the per-operand forwarding muxes with one block that resolves forwarding internally for NUM_OPS source operands. Priority is EX/MEM over MEM/WB, and XZR is never forwarded. Each channel has a hold register that preserves the resolved operand across multi-cycle ID/EX stalls, while the producing instruction drains out of EX/MEM and MEM/WB. It sits between the ID/EX pipeline register and the ALU input muxes.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- NUM_OPS, 2, number of operand channels (1..4); channel i uses bit slice [i*W +: W]
- REG_ADDR_W, 5, register index width; index all-ones (31) is XZR

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  ID/EX register held this cycle
- flush  in  1  ID/EX contents discarded this cycle
- idex_rs  in  NUM_OPS*REG_ADDR_W  source register index per channel
- idex_rdata  in  NUM_OPS*DATA_W  register-file read data per channel
- exmem_regwrite  in  1  EX/MEM instruction writes a register
- exmem_rd  in  REG_ADDR_W  EX/MEM destination
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB instruction writes a register
- memwb_rd  in  REG_ADDR_W  MEM/WB destination
- memwb_result  in  DATA_W  MEM/WB writeback data (after data-memory mux)
- operand  out  NUM_OPS*DATA_W  resolved operand per channel
- fwd_sel  out  NUM_OPS*2  per channel: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 hold register
- held  out  NUM_OPS  per-channel hold-active flag

## Operation
- Live select per channel i:
  - 10 if exmem_regwrite && exmem_rd==rs_i && rs_i!=31;
  - else 01 if memwb_regwrite && memwb_rd==rs_i && rs_i!=31;
  - else 00.
- When both stages match, EX/MEM wins.
- rs_i==31 always yields 00 and passes idex_rdata unchanged.
- Output with held[i]=0: operand_i = value chosen by the live select; fwd_sel_i = live select.
- Output with held[i]=1: operand_i = hold_i; fwd_sel_i = 11.
- Per-channel hold state machine (states LIVE, HOLD):
  - LIVE→HOLD at a clock edge with stall=1 and flush=0; hold_i captures the current live operand_i.
  - HOLD→HOLD while stall=1 and flush=0; hold_i is not recaptured.
  - HOLD→LIVE at an edge with stall=0, or flush=1.
- flush has priority over stall: no capture, and the channel goes to LIVE.
- Channels are independent but share the stall/flush controls, so in practice they transition together.

## Timing
- Outputs are combinational from inputs and state, with zero cycle latency in LIVE.
- In HOLD, outputs come from registers only and are insensitive to exmem_*/memwb_* changes.
- The first stall cycle is served live; the held value appears from the second stall cycle onward.
- The first cycle after the stall releases is served live.
- Reset (asynchronous assert, synchronous release on clk):
  - held=0, all hold_i=0, all counters=0;
  - outputs immediately reflect live selection.
- Reset asserted mid-stall drops to LIVE at once; the captured value is discarded.

## Configuration
- FWD_PERF_CNT_EN defined:
  - adds per-channel 32-bit counters cnt_exmem_i and cnt_memwb_i, readable on output perf_cnt (NUM_OPS*64 bits, {exmem, memwb} per channel);
  - each counter increments once per clock edge where the channel is LIVE, stall=0, and the live select equals that source;
  - counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no counters and no perf_cnt port; all other behaviour is identical.

## Test plan
- Priority: rs0=3, exmem_rd=3/regwrite=1/result=0xAA, memwb_rd=3/regwrite=1/result=0xBB, rdata0=0x11 -> operand0=0xAA, fwd_sel0=10.
- XZR: rs1=31, exmem_rd=31 regwrite=1, rdata1=0 -> operand1=0, fwd_sel1=00.
- Stall hold:
  - setup: rs0=5, exmem_rd=5, result=0x1234; stall=1 for 3 cycles;
  - cycle 2 onward: exmem_regwrite drops and memwb carries 0x9999 for rd=5;
  - required: operand0 stays 0x1234 with fwd_sel0=11 and held0=1 through the stall, then live 00/01 selection the cycle after release.
- Flush during stall: HOLD plus flush=1 at an edge -> held=0 next cycle, live selection restored, no capture.
- Reset mid-hold: rst_n low while held=1 -> held=0 and fwd_sel=live immediately, without waiting for a clock edge.
- With FWD_PERF_CNT_EN, the bench preloads both counters to 0xFFFFFFFE by force, then runs 3 EX/MEM forwards -> cnt_exmem saturates at 0xFFFFFFFF; cnt_memwb is unchanged.
